dma_desc_mux_credit: RTL

Parametrised descriptor multiplexer that arbitrates PORTS DMA descriptor request streams onto one DMA engine descriptor port and routes completion status back by tag. It sits between the per-client DMA users and a single read or write DMA interface engine. It extends the plain tag-extending mux with three behaviours:
- a per-port outstanding-operation credit limit;
- a registered output stage;
- per-port status accounting.

---
 rtl/dma_desc_mux_credit.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_desc_mux_credit.sv
// dma_desc_mux_credit: round-robin DMA descriptor mux with per-port credit limit,
// registered descriptor output, tag-based status routing and per-port accounting.
// Optional: define DMA_DESC_MUX_ERR_CNT_EN to enable per-port status error counters.
module dma_desc_mux_credit #(
    parameter int unsigned PORTS             = 4,
    parameter int unsigned DMA_ADDR_WIDTH    = 64,
    parameter int unsigned FUNCTION_ID_WIDTH = 8,
    parameter int unsigned RAM_SEL_WIDTH     = 2,
    parameter int unsigned RAM_ADDR_WIDTH    = 16,
    parameter int unsigned LEN_WIDTH         = 16,
    parameter int unsigned S_TAG_WIDTH       = 8,
    parameter int unsigned M_TAG_WIDTH       = S_TAG_WIDTH + $clog2(PORTS),
    parameter int unsigned MAX_OUTSTANDING   = 8,
    parameter int unsigned CNT_WIDTH         = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,

    input  logic [PORTS*DMA_ADDR_WIDTH-1:0]           s_desc_dma_addr,
    input  logic [PORTS*FUNCTION_ID_WIDTH-1:0]        s_desc_function_id,
    input  logic [PORTS*RAM_SEL_WIDTH-1:0]            s_desc_ram_sel,
    input  logic [PORTS*RAM_ADDR_WIDTH-1:0]           s_desc_ram_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]                s_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]              s_desc_tag,
    input  logic [PORTS-1:0]                          s_desc_valid,
    output logic [PORTS-1:0]                          s_desc_ready,

    output logic [DMA_ADDR_WIDTH-1:0]                 m_desc_dma_addr,
    output logic [FUNCTION_ID_WIDTH-1:0]              m_desc_function_id,
    output logic [RAM_SEL_WIDTH+$clog2(PORTS)-1:0]    m_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0]                 m_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                      m_desc_len,
    output logic [M_TAG_WIDTH-1:0]                    m_desc_tag,
    output logic                                      m_desc_valid,
    input  logic                                      m_desc_ready,

    input  logic [M_TAG_WIDTH-1:0]                    s_status_tag,
    input  logic [3:0]                                s_status_error,
    input  logic                                      s_status_valid,

    output logic [PORTS*S_TAG_WIDTH-1:0]              m_status_tag,
    output logic [PORTS*4-1:0]                        m_status_error,
    output logic [PORTS-1:0]                          m_status_valid,

    output logic [PORTS*CNT_WIDTH-1:0]                port_outstanding,
    output logic [PORTS-1:0]                          port_underflow,
    output logic [PORTS*16-1:0]                       port_err_count
);

    localparam int unsigned IDX_W   = $clog2(PORTS);
    localparam int unsigned M_SEL_W = RAM_SEL_WIDTH + IDX_W;

    // Arbitration state and per-port counters
    logic [IDX_W-1:0]     rr_q;
    logic [CNT_WIDTH-1:0] cnt_q [PORTS];
    logic [PORTS-1:0]     underflow_q;

    // Output descriptor register
    logic [DMA_ADDR_WIDTH-1:0]    desc_dma_addr_q;
    logic [FUNCTION_ID_WIDTH-1:0] desc_function_id_q;
    logic [M_SEL_W-1:0]           desc_ram_sel_q;
    logic [RAM_ADDR_WIDTH-1:0]    desc_ram_addr_q;
    logic [LEN_WIDTH-1:0]         desc_len_q;
    logic [M_TAG_WIDTH-1:0]       desc_tag_q;
    logic                         desc_valid_q;

    // Status output registers
    logic [S_TAG_WIDTH-1:0] st_tag_q [PORTS];
    logic [3:0]             st_err_q [PORTS];
    logic [PORTS-1:0]       st_valid_q;

    // Combinational arbitration / decode results
    logic [PORTS-1:0] eligible_c;
    logic             load_en_c;
    logic             grant_c;
    logic [IDX_W-1:0] grant_idx_c;
    logic [IDX_W-1:0] st_idx_c;
    logic [PORTS-1:0] st_hit_c;

    // Eligibility: valid request and credit available
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            eligible_c[i] = s_desc_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    // Round-robin search starting at rr_q, at most one grant when the output slot frees
    always_comb begin : p_arb
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        sum         = '0;
        cand        = '0;
        grant_c     = 1'b0;
        grant_idx_c = '0;
        load_en_c   = !desc_valid_q || m_desc_ready;
        for (int unsigned k = 0; k < PORTS; k++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(PORTS)) begin
                sum = sum - (IDX_W+1)'(PORTS);
            end
            cand = sum[IDX_W-1:0];
            if (load_en_c && !grant_c && eligible_c[cand]) begin
                grant_c     = 1'b1;
                grant_idx_c = cand;
            end
        end
    end

    // Ready is a one-hot of the granted port
    always_comb begin
        s_desc_ready = '0;
        if (grant_c) begin
            s_desc_ready[grant_idx_c] = 1'b1;
        end
    end

    // Status decode: tag MSBs pick the port, out-of-range indices match nothing
    always_comb begin
        st_idx_c = s_status_tag[M_TAG_WIDTH-1 -: IDX_W];
        st_hit_c = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            st_hit_c[i] = s_status_valid && (st_idx_c == IDX_W'(i));
        end
    end

    // Round-robin pointer: next search begins after the granted port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (grant_c) begin
            if (grant_idx_c == IDX_W'(PORTS - 1)) begin
                rr_q <= '0;
            end else begin
                rr_q <= grant_idx_c + IDX_W'(1);
            end
        end
    end

    // Output descriptor register: load on grant, clear when drained with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_dma_addr_q    <= '0;
            desc_function_id_q <= '0;
            desc_ram_sel_q     <= '0;
            desc_ram_addr_q    <= '0;
            desc_len_q         <= '0;
            desc_tag_q         <= '0;
            desc_valid_q       <= 1'b0;
        end else if (grant_c) begin
            desc_dma_addr_q    <= s_desc_dma_addr[grant_idx_c*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
            desc_function_id_q <= s_desc_function_id[grant_idx_c*FUNCTION_ID_WIDTH +: FUNCTION_ID_WIDTH];
            desc_ram_sel_q     <= {grant_idx_c, s_desc_ram_sel[grant_idx_c*RAM_SEL_WIDTH +: RAM_SEL_WIDTH]};
            desc_ram_addr_q    <= s_desc_ram_addr[grant_idx_c*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            desc_len_q         <= s_desc_len[grant_idx_c*LEN_WIDTH +: LEN_WIDTH];
            desc_tag_q         <= M_TAG_WIDTH'({grant_idx_c, s_desc_tag[grant_idx_c*S_TAG_WIDTH +: S_TAG_WIDTH]});
            desc_valid_q       <= 1'b1;
        end else if (m_desc_ready) begin
            desc_valid_q       <= 1'b0;
        end
    end

    // Outstanding counters: +1 on grant, -1 on status, both cancel; status at zero flags underflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                cnt_q[i] <= '0;
            end
            underflow_q <= '0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (grant_c && (grant_idx_c == IDX_W'(i)) && !st_hit_c[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (st_hit_c[i] && !(grant_c && (grant_idx_c == IDX_W'(i)))) begin
                    if (cnt_q[i] == '0) begin
                        underflow_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Status routing: one-cycle valid pulse, tag/error captured for the addressed port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                st_tag_q[i] <= '0;
                st_err_q[i] <= '0;
            end
            st_valid_q <= '0;
        end else begin
            st_valid_q <= st_hit_c;
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (st_hit_c[i]) begin
                    st_tag_q[i] <= s_status_tag[S_TAG_WIDTH-1:0];
                    st_err_q[i] <= s_status_error;
                end
            end
        end
    end

`ifdef DMA_DESC_MUX_ERR_CNT_EN
    logic [15:0] err_cnt_q [PORTS];

    // Saturating count of error statuses per port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                err_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (st_hit_c[i] && (s_status_error != 4'h0) && (err_cnt_q[i] != 16'hFFFF)) begin
                    err_cnt_q[i] <= err_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Pack error counters onto the flat output
    always_comb begin
        port_err_count = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            port_err_count[i*16 +: 16] = err_cnt_q[i];
        end
    end
`else
    assign port_err_count = '0;
`endif

    // Pack per-port registers onto flat outputs
    always_comb begin
        m_status_tag     = '0;
        m_status_error   = '0;
        port_outstanding = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            m_status_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] = st_tag_q[i];
            m_status_error[i*4 +: 4]                   = st_err_q[i];
            port_outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign m_status_valid     = st_valid_q;
    assign port_underflow     = underflow_q;
    assign m_desc_dma_addr    = desc_dma_addr_q;
    assign m_desc_function_id = desc_function_id_q;
    assign m_desc_ram_sel     = desc_ram_sel_q;
    assign m_desc_ram_addr    = desc_ram_addr_q;
    assign m_desc_len         = desc_len_q;
    assign m_desc_tag         = desc_tag_q;
    assign m_desc_valid       = desc_valid_q;

endmodule
